// File: rtl/alu_input_fsm_if.sv
// alu_input_fsm_if
//   Groups the raw button inputs and the strobe/indicator outputs of the
//   ALU input sequencer into one bundle.
//
//   enter      raw enter push-button (asynchronous, bouncing)
//   undo       raw undo push-button (only consumed when ALU_UNDO_EN is set)
//   load_A     one-cycle strobe: datapath captures operand A
//   load_B     one-cycle strobe: datapath captures operand B
//   load_Op    one-cycle strobe: datapath captures the opcode
//   updateRes  one-cycle strobe: datapath captures result and flags
//   state_leds one-hot state indicator {SHOW/UPDATE, WAIT_OP, WAIT_B, WAIT_A}
//
//   master: the sequencer side; slave: buttons + downstream datapath side.
interface alu_input_fsm_if;
    logic       enter;
    logic       undo;
    logic       load_A;
    logic       load_B;
    logic       load_Op;
    logic       updateRes;
    logic [3:0] state_leds;

    modport master (
        input  enter,
        input  undo,
        output load_A,
        output load_B,
        output load_Op,
        output updateRes,
        output state_leds
    );

    modport slave (
        output enter,
        output undo,
        input  load_A,
        input  load_B,
        input  load_Op,
        input  updateRes,
        input  state_leds
    );
endinterface

// File: rtl/alu_input_fsm.sv
// alu_input_fsm
//   Control stage in front of the registered ALU datapath. Conditions the raw
//   enter button (synchronize, debounce, rising-edge detect) and steps a Moore
//   FSM through operand A, operand B and opcode entry, emitting one registered
//   one-cycle strobe per step plus the result-update strobe.
//
//   Parameters:
//     DEB_CYCLES  stable cycles required before a button level is accepted (>= 1)
//
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous, active-high; forces WAIT_A and clears all state
//     bus    alu_input_fsm_if.master (enter/undo in, strobes and state_leds out)
//
//   Optional feature macro: ALU_UNDO_EN
//     When defined, the undo button gets its own conditioning chain and each
//     undo press steps the FSM back one entry state without a strobe.

// Single-button conditioning chain: two-flop synchronizer, counting debouncer
// and rising-edge pulse generator.
module alu_input_fsm_btn #(
    parameter int unsigned DEB_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic pulse
);
    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES);

    logic          sync1;
    logic          sync2;
    logic          deb;
    logic          deb_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            deb   <= 1'b0;
            deb_q <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_q <= deb;
            // The counter only advances while the synchronized level disagrees
            // with the accepted one; one agreeing cycle restarts the qualification.
            if (sync2 == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                deb <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Press only: a falling debounced level never produces a pulse.
    assign pulse = deb & ~deb_q;
endmodule

module alu_input_fsm #(
    parameter int unsigned DEB_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    alu_input_fsm_if.master       bus
);
    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        UPDATE,
        SHOW
    } state_t;

    localparam logic [3:0] LED_WAIT_A  = 4'b0001;
    localparam logic [3:0] LED_WAIT_B  = 4'b0010;
    localparam logic [3:0] LED_WAIT_OP = 4'b0100;
    localparam logic [3:0] LED_SHOW    = 4'b1000;

    state_t     state;
    logic       enter_p;
    logic       undo_p;
    logic       load_a_q;
    logic       load_b_q;
    logic       load_op_q;
    logic       update_res_q;
    logic [3:0] leds_q;

    alu_input_fsm_btn #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_enter_btn (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.enter),
        .pulse (enter_p)
    );

`ifdef ALU_UNDO_EN
    alu_input_fsm_btn #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_undo_btn (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.undo),
        .pulse (undo_p)
    );
`else
    logic unused_undo;
    assign unused_undo = bus.undo;
    assign undo_p      = 1'b0;
`endif

    // Strobes default low every cycle and are set only on the transition
    // edge, so each is exactly one cycle wide and never two at once.
    // Enter is tested before undo in every state: coincident pulses favour enter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= WAIT_A;
            load_a_q     <= 1'b0;
            load_b_q     <= 1'b0;
            load_op_q    <= 1'b0;
            update_res_q <= 1'b0;
            leds_q       <= LED_WAIT_A;
        end else begin
            load_a_q     <= 1'b0;
            load_b_q     <= 1'b0;
            load_op_q    <= 1'b0;
            update_res_q <= 1'b0;
            case (state)
                WAIT_A: begin
                    if (enter_p) begin
                        state    <= WAIT_B;
                        load_a_q <= 1'b1;
                        leds_q   <= LED_WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (enter_p) begin
                        state    <= WAIT_OP;
                        load_b_q <= 1'b1;
                        leds_q   <= LED_WAIT_OP;
                    end else if (undo_p) begin
                        state  <= WAIT_A;
                        leds_q <= LED_WAIT_A;
                    end
                end
                WAIT_OP: begin
                    if (enter_p) begin
                        state     <= UPDATE;
                        load_op_q <= 1'b1;
                        leds_q    <= LED_SHOW;
                    end else if (undo_p) begin
                        state  <= WAIT_B;
                        leds_q <= LED_WAIT_B;
                    end
                end
                UPDATE: begin
                    // Any button pulse seen here is intentionally dropped.
                    state        <= SHOW;
                    update_res_q <= 1'b1;
                    leds_q       <= LED_SHOW;
                end
                SHOW: begin
                    if (enter_p) begin
                        state  <= WAIT_A;
                        leds_q <= LED_WAIT_A;
                    end else if (undo_p) begin
                        state  <= WAIT_OP;
                        leds_q <= LED_WAIT_OP;
                    end
                end
                default: begin
                    state  <= WAIT_A;
                    leds_q <= LED_WAIT_A;
                end
            endcase
        end
    end

    assign bus.load_A     = load_a_q;
    assign bus.load_B     = load_b_q;
    assign bus.load_Op    = load_op_q;
    assign bus.updateRes  = update_res_q;
    assign bus.state_leds = leds_q;

    a_leds_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot(leds_q));
    a_strobes_exclusive: assert property (@(posedge clk) disable iff (reset)
        $onehot0({load_a_q, load_b_q, load_op_q, update_res_q}));
endmodule

// File: tb/tb_alu_input_fsm.sv
// tb_alu_input_fsm
//   Randomized self-checking bench for alu_input_fsm with DEB_CYCLES = 4.
//   A reference model tracks the abstract entry position (A, B, Op, Show) and
//   predicts each strobe's cycle from the press-to-strobe latency
//   (DEB_CYCLES + 3 edges after the final rise of a held button).
//   A small downstream datapath captures data_in on the strobes.
module tb_alu_input_fsm;
    localparam int DEB = 4;

    typedef struct {
        int         c;
        logic [3:0] v;
        logic [3:0] leds;
    } ev_t;

    logic clk = 1'b0;
    logic reset;

    alu_input_fsm_if bus ();

    alu_input_fsm #(
        .DEB_CYCLES (DEB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream datapath stand-in: opcode 2'b00 is addition.
    logic [15:0] data_in;
    logic [15:0] reg_a, reg_b, reg_res;
    logic [1:0]  reg_op;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_a <= '0; reg_b <= '0; reg_op <= '0; reg_res <= '0;
        end else begin
            if (bus.load_A)  reg_a  <= data_in;
            if (bus.load_B)  reg_b  <= data_in;
            if (bus.load_Op) reg_op <= data_in[1:0];
            if (bus.updateRes) begin
                case (reg_op)
                    2'b00:   reg_res <= reg_a + reg_b;
                    2'b01:   reg_res <= reg_a - reg_b;
                    2'b10:   reg_res <= reg_a & reg_b;
                    default: reg_res <= reg_a | reg_b;
                endcase
            end
        end
    end

    ev_t obs_q[$];
    ev_t exp_q[$];

    always @(negedge clk) begin
        ev_t e;
        e.c    = cyc;
        e.v    = {bus.updateRes, bus.load_Op, bus.load_B, bus.load_A};
        e.leds = bus.state_leds;
        if (e.v != 4'b0000) obs_q.push_back(e);
    end

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: entry position 0=A, 1=B, 2=Op, 3=Show.
    int p = 0;

    task automatic model_enter(input int f);
        ev_t e;
        case (p)
            0: begin e = '{c: f, v: 4'b0001, leds: 4'b0010}; exp_q.push_back(e); p = 1; end
            1: begin e = '{c: f, v: 4'b0010, leds: 4'b0100}; exp_q.push_back(e); p = 2; end
            2: begin
                e = '{c: f, v: 4'b0100, leds: 4'b1000}; exp_q.push_back(e);
                e = '{c: f + 1, v: 4'b1000, leds: 4'b1000}; exp_q.push_back(e);
                p = 3;
            end
            default: p = 0;
        endcase
    endtask

    task automatic model_undo();
        if (p > 0) p = p - 1;
    endtask

    task automatic apply_reset();
        bus.enter = 1'b0;
        bus.undo  = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        p = 0;
        obs_q.delete();
        exp_q.delete();
    endtask

    // Drives optional bounce glitches, then a held press, then a quiet gap.
    // fire = cycle stamp at which the resulting strobe is expected.
    task automatic drive_press(input int n_gl, input int gw, input int gl,
                               input int hold, input int gap,
                               input bit do_e, input bit do_u, output int fire);
        for (int g = 0; g < n_gl; g++) begin
            bus.enter = do_e; bus.undo = do_u;
            repeat (gw) @(posedge clk);
            #1;
            bus.enter = 1'b0; bus.undo = 1'b0;
            repeat (gl) @(posedge clk);
            #1;
        end
        bus.enter = do_e; bus.undo = do_u;
        @(posedge clk); #1;
        fire = cyc + DEB + 3;
        repeat (hold - 1) @(posedge clk);
        #1;
        bus.enter = 1'b0; bus.undo = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int f, c0;
        bus.enter = 1'b0; bus.undo = 1'b0; data_in = '0;
        reset = 1'b0;
        #1 reset = 1'b1;
        #2;
        n_total++;
        if (bus.state_leds !== 4'b0001 || {bus.updateRes, bus.load_Op, bus.load_B, bus.load_A} !== 4'b0000)
            $display("FAIL rst_initial: leds=%b strobes=%b, expected leds=0001 strobes=0000",
                     bus.state_leds, {bus.updateRes, bus.load_Op, bus.load_B, bus.load_A});
        else n_pass++;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (bus.state_leds !== 4'b0001)
            $display("FAIL rst_release: leds=%b, expected 0001", bus.state_leds);
        else n_pass++;
        p = 0; obs_q.delete(); exp_q.delete();

        drive_press(0, 0, 0, DEB + 3, DEB + 8, 1'b1, 1'b0, f); model_enter(f);
        drive_press(0, 0, 0, DEB + 3, DEB + 8, 1'b1, 1'b0, f); model_enter(f);
        n_total++;
        if (bus.state_leds !== 4'b0100)
            $display("FAIL rst_pre_wait_op: leds=%b, expected 0100", bus.state_leds);
        else n_pass++;

        // Third press; reset lands while load_Op is high, between clock edges.
        bus.enter = 1'b1;
        @(posedge clk); #1;
        c0 = cyc;
        repeat (DEB + 3) @(posedge clk);
        #1;
        n_total++;
        if (bus.load_Op !== 1'b1 || cyc !== c0 + DEB + 3)
            $display("FAIL rst_pre_strobe: load_Op=%b at cycle %0d, expected 1 at cycle %0d",
                     bus.load_Op, cyc, c0 + DEB + 3);
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_total++;
        if (bus.state_leds !== 4'b0001 || {bus.updateRes, bus.load_Op, bus.load_B, bus.load_A} !== 4'b0000)
            $display("FAIL rst_async: leds=%b strobes=%b, expected leds=0001 strobes=0000",
                     bus.state_leds, {bus.updateRes, bus.load_Op, bus.load_B, bus.load_A});
        else n_pass++;

        n_total++;
        if (obs_q.size() !== exp_q.size())
            $display("FAIL rst_pre_count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_total++;
            if (obs_q[i].c !== exp_q[i].c || obs_q[i].v !== exp_q[i].v || obs_q[i].leds !== exp_q[i].leds)
                $display("FAIL rst_pre_ev%0d: got cyc=%0d strobes=%b leds=%b, expected cyc=%0d strobes=%b leds=%b",
                         i, obs_q[i].c, obs_q[i].v, obs_q[i].leds, exp_q[i].c, exp_q[i].v, exp_q[i].leds);
            else n_pass++;
        end

        // Button still held through reset; nothing may survive it.
        repeat (DEB + 4) @(posedge clk);
        #1 bus.enter = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        p = 0; obs_q.delete(); exp_q.delete();
        repeat (DEB + 8) @(posedge clk);
        #1;
        drive_press(0, 0, 0, DEB + 3, DEB + 8, 1'b1, 1'b0, f); model_enter(f);
        n_total++;
        if (obs_q.size() !== 1 || exp_q.size() !== 1)
            $display("FAIL rst_post_count: got %0d strobes, expected 1", obs_q.size());
        else if (obs_q[0].c !== exp_q[0].c || obs_q[0].v !== exp_q[0].v)
            $display("FAIL rst_post_load_A: got cyc=%0d strobes=%b, expected cyc=%0d strobes=%b",
                     obs_q[0].c, obs_q[0].v, exp_q[0].c, exp_q[0].v);
        else n_pass++;
    endtask

    task automatic test_clean_press();
        int f;
        apply_reset();
        drive_press(0, 0, 0, 30, DEB + 8, 1'b1, 1'b0, f); model_enter(f);
        n_total++;
        if (obs_q.size() !== exp_q.size())
            $display("FAIL clean_count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_total++;
            if (obs_q[i].c !== exp_q[i].c || obs_q[i].v !== exp_q[i].v || obs_q[i].leds !== exp_q[i].leds)
                $display("FAIL clean_ev%0d: got cyc=%0d strobes=%b leds=%b, expected cyc=%0d strobes=%b leds=%b",
                         i, obs_q[i].c, obs_q[i].v, obs_q[i].leds, exp_q[i].c, exp_q[i].v, exp_q[i].leds);
            else n_pass++;
        end
    endtask

    task automatic test_bounce();
        int f;
        apply_reset();
        drive_press(5, 2, 2, DEB + 6, DEB + 8, 1'b1, 1'b0, f); model_enter(f);
        n_total++;
        if (obs_q.size() !== exp_q.size())
            $display("FAIL bounce_count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_total++;
            if (obs_q[i].c !== exp_q[i].c || obs_q[i].v !== exp_q[i].v || obs_q[i].leds !== exp_q[i].leds)
                $display("FAIL bounce_ev%0d: got cyc=%0d strobes=%b leds=%b, expected cyc=%0d strobes=%b leds=%b",
                         i, obs_q[i].c, obs_q[i].v, obs_q[i].leds, exp_q[i].c, exp_q[i].v, exp_q[i].leds);
            else n_pass++;
        end
    endtask

    task automatic test_full_sequence();
        int f;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            drive_press(0, 0, 0, DEB + 2, DEB + 8, 1'b1, 1'b0, f); model_enter(f);
            n_total++;
            if (bus.state_leds !== 4'(1 << p))
                $display("FAIL seq_leds%0d: leds=%b, expected %b", k, bus.state_leds, 4'(1 << p));
            else n_pass++;
        end
        n_total++;
        if (obs_q.size() !== exp_q.size())
            $display("FAIL seq_count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_total++;
            if (obs_q[i].c !== exp_q[i].c || obs_q[i].v !== exp_q[i].v || obs_q[i].leds !== exp_q[i].leds)
                $display("FAIL seq_ev%0d: got cyc=%0d strobes=%b leds=%b, expected cyc=%0d strobes=%b leds=%b",
                         i, obs_q[i].c, obs_q[i].v, obs_q[i].leds, exp_q[i].c, exp_q[i].v, exp_q[i].leds);
            else n_pass++;
        end
    endtask

    task automatic test_integration();
        int f;
        logic [15:0] a, b, want;
        apply_reset();
        for (int round = 0; round < 2; round++) begin
            a = (round == 0) ? 16'h0005 : 16'($urandom);
            b = (round == 0) ? 16'h0003 : 16'($urandom);
            want = a + b;
            data_in = a;
            drive_press(0, 0, 0, DEB + 2, DEB + 8, 1'b1, 1'b0, f); model_enter(f);
            data_in = b;
            drive_press(0, 0, 0, DEB + 2, DEB + 8, 1'b1, 1'b0, f); model_enter(f);
            data_in = 16'h0000;
            drive_press(0, 0, 0, DEB + 2, DEB + 8, 1'b1, 1'b0, f); model_enter(f);
            n_total++;
            if (reg_res !== want)
                $display("FAIL integ_res%0d: result=%h, expected %h", round, reg_res, want);
            else n_pass++;
            drive_press(0, 0, 0, DEB + 2, DEB + 8, 1'b1, 1'b0, f); model_enter(f);
        end
    endtask

    task automatic test_random();
        int f, kind;
        apply_reset();
        for (int k = 0; k < 30; k++) begin
`ifdef ALU_UNDO_EN
            kind = $urandom_range(0, 3);
`else
            kind = 2;
`endif
            drive_press($urandom_range(0, 3), $urandom_range(1, DEB - 1), $urandom_range(1, 3),
                        $urandom_range(DEB + 1, DEB + 10), $urandom_range(DEB + 6, DEB + 12),
                        kind != 0, kind <= 1, f);
            if (kind == 0) model_undo();
            else model_enter(f);
            n_total++;
            if (bus.state_leds !== 4'(1 << p))
                $display("FAIL rand_leds%0d: leds=%b, expected %b", k, bus.state_leds, 4'(1 << p));
            else n_pass++;
        end
        n_total++;
        if (obs_q.size() !== exp_q.size())
            $display("FAIL rand_count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_total++;
            if (obs_q[i].c !== exp_q[i].c || obs_q[i].v !== exp_q[i].v || obs_q[i].leds !== exp_q[i].leds)
                $display("FAIL rand_ev%0d: got cyc=%0d strobes=%b leds=%b, expected cyc=%0d strobes=%b leds=%b",
                         i, obs_q[i].c, obs_q[i].v, obs_q[i].leds, exp_q[i].c, exp_q[i].v, exp_q[i].leds);
            else n_pass++;
        end
    endtask

`ifdef ALU_UNDO_EN
    task automatic test_undo();
        int f;
        apply_reset();
        drive_press(0, 0, 0, DEB + 2, DEB + 8, 1'b1, 1'b0, f); model_enter(f);
        drive_press(0, 0, 0, DEB + 2, DEB + 8, 1'b1, 1'b0, f); model_enter(f);
        drive_press(0, 0, 0, DEB + 2, DEB + 8, 1'b0, 1'b1, f); model_undo();
        n_total++;
        if (bus.state_leds !== 4'b0010 || 4'(1 << p) !== bus.state_leds)
            $display("FAIL undo_step_back: leds=%b, expected 0010", bus.state_leds);
        else n_pass++;
        drive_press(0, 0, 0, DEB + 2, DEB + 8, 1'b1, 1'b1, f); model_enter(f);
        n_total++;
        if (bus.state_leds !== 4'b0100)
            $display("FAIL undo_enter_wins: leds=%b, expected 0100", bus.state_leds);
        else n_pass++;
        n_total++;
        if (obs_q.size() !== exp_q.size())
            $display("FAIL undo_count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_total++;
            if (obs_q[i].c !== exp_q[i].c || obs_q[i].v !== exp_q[i].v || obs_q[i].leds !== exp_q[i].leds)
                $display("FAIL undo_ev%0d: got cyc=%0d strobes=%b leds=%b, expected cyc=%0d strobes=%b leds=%b",
                         i, obs_q[i].c, obs_q[i].v, obs_q[i].leds, exp_q[i].c, exp_q[i].v, exp_q[i].leds);
            else n_pass++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_full_sequence();
        test_integration();
        test_random();
`ifdef ALU_UNDO_EN
        test_undo();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/alu_input_fsm.md
# alu_input_fsm

Control stage that sits directly upstream of the registered ALU datapath. It turns a single raw "enter" push-button into the four one-cycle load strobes that datapath consumes: `load_A`, `load_B`, `load_Op` and `updateRes`. Operands and opcode are entered in that order from the shared `data_in` switches. The block debounces and edge-detects the button, sequences entry with a Moore-style FSM, and drives one-hot state LEDs so the user knows what to enter next.

## Interface
- `DEB_CYCLES`, default 100000: consecutive stable cycles required before a button level is accepted. Legal range is ≥ 1. The counter width is `$clog2(DEB_CYCLES+1)`.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high. Clears all state immediately.
- `enter`  in  1  raw, asynchronous push-button (bouncing).
- `undo`  in  1  raw, asynchronous push-button. Used only with `ALU_UNDO_EN`.
- `load_A`  out  1  one-cycle strobe: capture `data_in` as operand A.
- `load_B`  out  1  one-cycle strobe: capture `data_in` as operand B.
- `load_Op`  out  1  one-cycle strobe: capture `data_in[1:0]` as opcode.
- `updateRes`  out  1  one-cycle strobe: capture ALU result and flags.
- `state_leds`  out  4  one-hot state indicator: bit0 WAIT_A, bit1 WAIT_B, bit2 WAIT_OP, bit3 SHOW. Bit3 is also lit during UPDATE.

## Operation
**Button conditioning** (identical instance per button):
- Two-flop synchronizer feeds the debouncer.
- The debounced level flips only after the synchronized level has differed from it for `DEB_CYCLES` consecutive cycles. Any agreeing cycle clears the counter.
- A press produces a one-cycle pulse on the rising edge of the debounced level.
- A held button yields exactly one pulse. Release produces no pulse.

**FSM states:** WAIT_A (reset), WAIT_B, WAIT_OP, UPDATE, SHOW.
- WAIT_A + enter pulse → WAIT_B; `load_A`=1 next cycle.
- WAIT_B + enter pulse → WAIT_OP; `load_B`=1 next cycle.
- WAIT_OP + enter pulse → UPDATE; `load_Op`=1 next cycle.
- UPDATE → SHOW unconditionally; `updateRes`=1 next cycle.
- SHOW + enter pulse → WAIT_A; no strobe. Results stay displayed downstream until the next UPDATE.
- All strobes are registered, so at most one is high in any cycle and each is exactly one cycle wide.
- An enter pulse arriving in UPDATE is dropped.
- `data_in` is not an input here. The user holds the switches stable; the datapath samples them on the strobe cycle.

**Reset:**
- `reset` high at any time forces WAIT_A, clears all strobes, debounce counters, debounced levels and synchronizers.
- `state_leds` = 4'b0001 while reset is asserted and after it is released.
- A press in progress when reset hits is discarded.
- The downstream registers share `reset`, so the datapath and this FSM realign.

## Timing
- Press latency: with raw `enter` first sampled high at edge 0 and held, the debounced level rises at edge `DEB_CYCLES`+2, and the strobe is high for the cycle following edge `DEB_CYCLES`+3.
- `load_Op` high in cycle k → `updateRes` high in cycle k+1. The opcode register updates at the end of k, so the ALU output is valid during k+1.
- Minimum spacing between accepted presses is 2·`DEB_CYCLES` cycles, so UPDATE (one cycle) can never overlap a legal pulse.
- `state_leds` changes on the same edge as the state register.

## Configuration
`ALU_UNDO_EN`:
- **Defined:**
  - `undo` gets its own conditioning chain. A debounced undo pulse steps back one state: WAIT_B→WAIT_A, WAIT_OP→WAIT_B, SHOW→WAIT_OP. It emits no strobe.
  - Undo in WAIT_A or UPDATE is ignored.
  - If enter and undo pulses coincide in one cycle, enter wins and undo is dropped.
  - Re-entering a value after undo overwrites the previous register contents through the normal strobe.
- **Undefined:** `undo` is unused, no second debouncer is synthesized, and behaviour is identical to the FSM above.

## Test plan
Unless noted, every scenario runs with `DEB_CYCLES`=4.
- **Reset:** assert `reset` mid-sequence (in WAIT_OP) → all strobes 0 and `state_leds`=0001 within the same cycle, with no clock needed. After release, the first enter gives `load_A`.
- **Clean press:** hold `enter` high from edge 0 → `load_A` high only in the cycle after edge 7. It is never reasserted while held; release gives no pulse.
- **Bounce:** toggle `enter` high/low every 2 cycles for 20 cycles, then hold high → exactly one `load_A`, 7 cycles after the final rise.
- **Full sequence:** four clean presses → strobes in order `load_A`, `load_B`, `load_Op`, then `updateRes` exactly 1 cycle after `load_Op`. `state_leds` reads 0001→0010→0100→1000, then returns to 0001 after the fourth press.
- **Integration:** drive `data_in` 0x0005, 0x0003, opcode 2'b00 with presses → downstream result register = 0x0008 after `updateRes`.
- **Undo (`ALU_UNDO_EN`):** in WAIT_OP press undo → WAIT_B with no strobe. A simultaneous enter+undo in WAIT_B → WAIT_OP with `load_B` asserted.
